iq_window_framer: RTL and testbench

- Upstream neighbour of the FSK CNN demodulator core.
- Joins the independent I and Q AXI4-Stream sample streams into lock-step {I,Q} pairs.
- Slices the paired stream into fixed windows of WIN_LEN samples, one CNN inference each, and marks the end of every window with m_axis_tlast.
- Zero-pads a window cut short by an input packet end, and flags I/Q tlast misalignment.

---
 rtl/fsk_rx_pkg.sv | 20 ++
 rtl/axis_skid_buffer.sv | 67 ++++++
 rtl/iq_window_framer.sv | 107 ++++++++++
 tb/tb_iq_window_framer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_rx_pkg.sv
// Shared types and defaults for the FSK receive front end.
package fsk_rx_pkg;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_WIN_LEN  = 32;
    localparam int DEF_FCNT_W   = 16;

    typedef enum logic {
        RUN = 1'b0,
        PAD = 1'b1
    } framer_state_t;

    typedef struct packed {
        logic [DEF_SAMPLE_W-1:0] i;
        logic [DEF_SAMPLE_W-1:0] q;
        logic                    last;
        logic                    pad;
    } iq_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid: head register drives the master side, second entry
// absorbs one beat while the head is stalled.
module axis_skid_buffer #(
    parameter int W = 34
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [W-1:0] m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i
);

    logic         out_vld_q, out_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] out_dat_q, out_dat_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         pop, push;

    assign s_ready_o = !skid_vld_q;
    assign m_data_o  = out_dat_q;
    assign m_valid_o = out_vld_q;
    assign pop       = out_vld_q && m_ready_i;
    assign push      = s_valid_i && !skid_vld_q;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (pop) begin
            // A full skid blocks pushes, so refill from skid never races a new beat.
            if (skid_vld_q) begin
                out_dat_d  = skid_dat_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = push;
                if (push) out_dat_d = s_data_i;
            end
        end else if (push) begin
            if (!out_vld_q) begin
                out_vld_d = 1'b1;
                out_dat_d = s_data_i;
            end else begin
                skid_vld_d = 1'b1;
                skid_dat_d = s_data_i;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

endmodule

// File: rtl/iq_window_framer.sv
// Pairs I/Q streams, cuts them into WIN_LEN-sample windows with tlast, and
// zero-pads a window cut short by an input packet end.
module iq_window_framer
    import fsk_rx_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int WIN_LEN  = DEF_WIN_LEN,
    parameter int FCNT_W   = DEF_FCNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SAMPLE_W-1:0]   s_axis_i_tdata,
    input  logic                  s_axis_i_tvalid,
    output logic                  s_axis_i_tready,
    input  logic                  s_axis_i_tlast,
    input  logic [SAMPLE_W-1:0]   s_axis_q_tdata,
    input  logic                  s_axis_q_tvalid,
    output logic                  s_axis_q_tready,
    input  logic                  s_axis_q_tlast,
    output logic [2*SAMPLE_W-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  err_tlast_mismatch,
    output logic [FCNT_W-1:0]     frame_count
);

    localparam int CNT_W = $clog2(WIN_LEN);
    localparam int BW    = 2*SAMPLE_W + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

    framer_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              skid_rdy, accept, push, win_end, eff_last;
    logic [BW-1:0]     push_beat, out_beat;

    // Gated by reset so the ready outputs read 0 while reset is held.
    assign accept   = !reset && (state_q == RUN) && s_axis_i_tvalid && s_axis_q_tvalid && skid_rdy;
    assign win_end  = (cnt_q == CNT_LAST);
    assign eff_last = s_axis_i_tlast || s_axis_q_tlast;

    assign s_axis_i_tready = accept;
    assign s_axis_q_tready = accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        fcnt_d    = fcnt_q;
        push      = 1'b0;
        push_beat = {win_end, 1'b0, s_axis_i_tdata, s_axis_q_tdata};
        unique case (state_q)
            RUN: begin
                push = accept;
                if (accept) begin
                    if (s_axis_i_tlast != s_axis_q_tlast) err_d = 1'b1;
                    if (eff_last && !win_end) state_d = PAD;
                end
            end
            PAD: begin
                push      = skid_rdy;
                push_beat = {win_end, 1'b1, {(2*SAMPLE_W){1'b0}}};
                if (skid_rdy && win_end) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (push) begin
            cnt_d = win_end ? '0 : cnt_q + CNT_W'(1);
            if (win_end) fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    axis_skid_buffer #(.W(BW)) u_out (
        .clock     (clock),
        .reset     (reset),
        .s_data_i  (push_beat),
        .s_valid_i (push),
        .s_ready_o (skid_rdy),
        .m_data_o  (out_beat),
        .m_valid_o (m_axis_tvalid),
        .m_ready_i (m_axis_tready)
    );

    assign m_axis_tdata       = out_beat[2*SAMPLE_W-1:0];
    assign m_axis_tuser       = out_beat[2*SAMPLE_W];
    assign m_axis_tlast       = out_beat[BW-1];
    assign err_tlast_mismatch = err_q;
    assign frame_count        = fcnt_q;

endmodule

// File: tb/tb_iq_window_framer.sv
// Self-checking bench: handshake table, directed window/pad/reset sequences and
// randomized traffic scored against a window-position reference model.
module tb_iq_window_framer;
    import fsk_rx_pkg::*;

    localparam int SW = DEF_SAMPLE_W;
    localparam int WL = DEF_WIN_LEN;
    localparam int FW = DEF_FCNT_W;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] i_tdata, q_tdata;
    logic          iv, qv, i_tlast, q_tlast;
    logic          i_tready, q_tready;
    logic [2*SW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tlast, m_tuser, err;
    logic [FW-1:0] fc;

    iq_window_framer #(.SAMPLE_W(SW), .WIN_LEN(WL), .FCNT_W(FW)) dut (
        .clock(clk), .reset(rst),
        .s_axis_i_tdata(i_tdata), .s_axis_i_tvalid(iv), .s_axis_i_tready(i_tready), .s_axis_i_tlast(i_tlast),
        .s_axis_q_tdata(q_tdata), .s_axis_q_tvalid(qv), .s_axis_q_tready(q_tready), .s_axis_q_tlast(q_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .err_tlast_mismatch(err), .frame_count(fc)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int rmode = 0;
    int n_beats, n_last, n_pad, first_vld_cyc;

    // Reference model: expected output beats derived from window position only.
    iq_beat_t exp_q[$];
    int       mcnt;
    int       mfc;
    bit       merr;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        exp_q.delete();
        mcnt = 0; mfc = 0; merr = 0;
    endfunction

    function automatic void model_pair(logic [SW-1:0] i, logic [SW-1:0] q, bit il, bit ql);
        iq_beat_t b;
        if (il != ql) merr = 1;
        b.i = i; b.q = q; b.pad = 1'b0; b.last = (mcnt == WL-1);
        exp_q.push_back(b);
        if (b.last) begin
            mcnt = 0; mfc++;
        end else if (il || ql) begin
            for (int p = mcnt + 1; p < WL; p++) begin
                b.i = '0; b.q = '0; b.pad = 1'b1; b.last = (p == WL-1);
                exp_q.push_back(b);
            end
            mcnt = 0; mfc++;
        end else begin
            mcnt++;
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: m_tready = 1'b1;
                1: m_tready = ~m_tready;
                2: m_tready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    // Output monitor: scoreboard, stall stability and ready rule.
    initial begin
        bit            prev_stall;
        logic [2*SW+2:0] prev;
        iq_beat_t      e;
        prev_stall = 0; prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                check("rdy_rule", 64'((i_tready != q_tready) || (i_tready && !(iv && qv))), 0);
                if (prev_stall)
                    check("stall_hold", {m_tvalid, m_tlast, m_tuser, m_tdata}, prev);
                if (m_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {m_tlast, m_tuser, m_tdata}, {e.last, e.pad, e.i, e.q});
                    end
                    n_beats++;
                    if (m_tlast) n_last++;
                    if (m_tuser) n_pad++;
                end
                prev_stall = m_tvalid && !m_tready;
                prev = {m_tvalid, m_tlast, m_tuser, m_tdata};
            end
        end
    end

    task automatic idle();
        iv = 0; qv = 0; i_tlast = 0; q_tlast = 0;
    endtask

    task automatic send_pair(input logic [SW-1:0] i, input logic [SW-1:0] q, input bit il, input bit ql,
                             input int idly, input int qdly, output int waited);
        bit done;
        int c;
        done = 0; c = 0; waited = 0;
        i_tdata = i; q_tdata = q; i_tlast = il; q_tlast = ql;
        while (!done && c < 200) begin
            iv = (c >= idly); qv = (c >= qdly);
            @(negedge clk);
            if (i_tready) begin
                model_pair(i, q, il, ql);
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
            c++;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        idle();
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain", exp_q.size(), 0);
        @(negedge clk);
        check("idle_vld", m_tvalid, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        check("reset_outs", {i_tready, q_tready, m_tvalid, m_tdata, m_tlast, m_tuser, err, fc}, 0);
        model_clear();
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        n_beats = 0; n_last = 0; n_pad = 0; first_vld_cyc = -1;
    endtask

    typedef struct {
        bit iv, qv, mr, rdy, vld;
    } vec_t;

    initial begin
        vec_t tbl[9];
        int   w, a0, c0, k, si, sq;
        bit   il, ql;

        tbl[0] = '{0, 0, 1, 0, 0};
        tbl[1] = '{1, 0, 1, 0, 0};
        tbl[2] = '{0, 1, 1, 0, 0};
        tbl[3] = '{1, 1, 0, 1, 0};
        tbl[4] = '{1, 1, 0, 1, 1};
        tbl[5] = '{1, 1, 0, 0, 1};
        tbl[6] = '{1, 1, 1, 0, 1};
        tbl[7] = '{1, 1, 1, 1, 1};
        tbl[8] = '{0, 0, 1, 0, 1};

        model_clear();
        n_beats = 0; n_last = 0; n_pad = 0; first_vld_cyc = -1;
        rst = 1; i_tdata = 16'h1234; q_tdata = 16'h5678; iv = 1; qv = 1; i_tlast = 0; q_tlast = 0;
        #3 check("reset_hold", {i_tready, q_tready, m_tvalid, m_tdata, m_tlast, m_tuser, err, fc}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0; idle();

        // Handshake table: lone valids, skid fill and release.
        rmode = 3;
        for (int r = 0; r < 9; r++) begin
            iv = tbl[r].iv; qv = tbl[r].qv; m_tready = tbl[r].mr;
            i_tdata = 16'(16'h1000 + r); q_tdata = 16'(16'h2000 + r);
            @(negedge clk);
            check("tbl_rdy", {i_tready, q_tready}, {tbl[r].rdy, tbl[r].rdy});
            check("tbl_vld", m_tvalid, tbl[r].vld);
            if (tbl[r].rdy) model_pair(i_tdata, q_tdata, 0, 0);
            @(posedge clk); #1;
        end
        rmode = 0;
        drain();

        // 64 back-to-back sine/cosine pairs.
        do_reset();
        a0 = 0; c0 = 0;
        for (int n = 0; n < 64; n++) begin
            si = $rtoi(12000.0 * $sin(6.283185307 * n / 16.0));
            sq = $rtoi(12000.0 * $cos(6.283185307 * n / 16.0));
            send_pair(16'(si), 16'(sq), 0, 0, 0, 0, w);
            if (n == 0) a0 = cyc;
            if (n == 63) c0 = cyc;
        end
        check("t1_latency", first_vld_cyc, a0);
        check("t1_b2b", c0 - a0, 63);
        drain();
        check("t1_beats", n_beats, 64);
        check("t1_tlast", n_last, 2);
        check("t1_tuser", n_pad, 0);
        check("t1_fc", fc, 2);

        // I leads Q: no consumption until both valid, no slip.
        do_reset();
        send_pair(16'hA000, 16'hB000, 0, 0, 0, 5, w);
        check("t2_wait", w, 5);
        for (int n = 1; n < 8; n++) begin
            send_pair(16'($urandom), 16'($urandom), 0, 0, $urandom_range(0, 3), $urandom_range(0, 3), w);
        end
        drain();
        check("t2_beats", n_beats, 8);

        // Toggling downstream ready over 96 pairs.
        do_reset();
        rmode = 1;
        for (int n = 0; n < 96; n++) send_pair(16'($urandom), 16'($urandom), 0, 0, 0, 0, w);
        drain();
        rmode = 0;
        check("t3_beats", n_beats, 96);
        check("t3_fc", fc, 3);

        // Early packet end at cnt=9 pads 22 beats.
        do_reset();
        for (int n = 0; n < 10; n++) send_pair(16'(n + 1), 16'(n + 100), n == 9, n == 9, 0, 0, w);
        send_pair(16'h7777, 16'h8888, 0, 0, 0, 0, w);
        check("t4_pad_stall", w, 22);
        drain();
        check("t4_pads", n_pad, 22);
        check("t4_tlast", n_last, 1);
        check("t4_fc", fc, 1);

        // Mismatched tlast on the window-closing pair.
        do_reset();
        for (int n = 0; n < 31; n++) send_pair(16'($urandom), 16'($urandom), 0, 0, 0, 0, w);
        check("t5_err_pre", err, 0);
        send_pair(16'h4321, 16'h8765, 1, 0, 0, 0, w);
        check("t5_err", err, 1);
        idle();
        for (int n = 0; n < 5; n++) send_pair(16'($urandom), 16'($urandom), 0, 0, 0, 0, w);
        drain();
        check("t5_err_sticky", err, 1);
        check("t5_pads", n_pad, 0);
        check("t5_fc", fc, 1);

        // Reset mid-window discards the partial window.
        do_reset();
        for (int n = 0; n < 12; n++) send_pair(16'($urandom), 16'($urandom), 0, 0, 0, 0, w);
        do_reset();
        for (int n = 0; n < 32; n++) send_pair(16'($urandom), 16'($urandom), 0, 0, 0, 0, w);
        drain();
        check("t6_tlast", n_last, 1);
        check("t6_fc", fc, 1);
        check("t6_err", err, 0);

        // Randomized traffic against the model.
        do_reset();
        rmode = 2;
        for (int n = 0; n < 300; n++) begin
            il = ($urandom_range(0, 15) == 0);
            ql = ($urandom_range(0, 31) == 0) ? !il : il;
            send_pair(16'($urandom), 16'($urandom), il, ql, $urandom_range(0, 2), $urandom_range(0, 2), w);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                k = $urandom_range(1, 3);
                repeat (k) @(posedge clk);
                #1;
            end
        end
        drain();
        rmode = 0;
        check("rnd_fc", fc, 16'(mfc));
        check("rnd_err", err, merr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
